// File: rtl/capture_ram_pkg.sv
// Shared types and modulo-depth pointer helpers for the capture memory.
package capture_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  function automatic int unsigned mod_inc(input int unsigned a, input int unsigned sz);
    return (a == sz - 1) ? 32'd0 : a + 32'd1;
  endfunction

  function automatic int unsigned mod_dec(input int unsigned a, input int unsigned sz);
    return (a == 32'd0) ? sz - 1 : a - 32'd1;
  endfunction

  // (a - b) mod sz, valid for a < sz and b <= sz
  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned sz);
    return (a >= b) ? a - b : a + sz - b;
  endfunction

endpackage

// File: rtl/capture_ram_if.sv
// Sample write stream and host read stream bundled between sampler, capture RAM and host.
interface capture_ram_if #(
  parameter int MDW = 32,
  parameter int MKW = MDW / 8
);
  logic           mwr_tready;
  logic           mwr_tvalid;
  logic           mwr_tlast;
  logic [MKW-1:0] mwr_tkeep;
  logic [MDW-1:0] mwr_tdata;
  logic           mrd_tready;
  logic           mrd_tvalid;
  logic           mrd_tlast;
  logic [MKW-1:0] mrd_tkeep;
  logic [MDW-1:0] mrd_tdata;

  modport slave (
    output mwr_tready,
    input  mwr_tvalid, mwr_tlast, mwr_tkeep, mwr_tdata,
    input  mrd_tready,
    output mrd_tvalid, mrd_tlast, mrd_tkeep, mrd_tdata
  );

  modport master (
    input  mwr_tready,
    output mwr_tvalid, mwr_tlast, mwr_tkeep, mwr_tdata,
    output mrd_tready,
    input  mrd_tvalid, mrd_tlast, mrd_tkeep, mrd_tdata
  );
endinterface

// File: rtl/capture_ram_lane.sv
// One byte lane of capture storage: 8 data bits plus the keep bit, registered read.
module capture_ram_lane #(
  parameter int MSZ = 6144,
  parameter int MAW = 13
) (
  input  logic           clk,
  input  logic           we,
  input  logic           wkeep,
  input  logic [MAW-1:0] waddr,
  input  logic [7:0]     wdata,
  input  logic           re,
  input  logic [MAW-1:0] raddr,
  output logic [7:0]     rdata,
  output logic           rkeep
);

  logic [7:0] dmem [MSZ];
  logic       kmem [MSZ];

  // keep is always recorded; data only when the lane is kept
  always_ff @(posedge clk) begin
    if (we) begin
      kmem[waddr] <= wkeep;
      if (wkeep) dmem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= dmem[raddr];
      rkeep <= kmem[raddr];
    end
  end

endmodule

// File: rtl/capture_ram.sv
// Capture memory: one-shot or ring capture of a sample stream, replayed forward or newest-first.
module capture_ram
  import capture_ram_pkg::*;
#(
  parameter int MDW = 32,
  parameter int MKW = MDW / 8,
  parameter int MSZ = 6144,
  parameter int MAW = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_start,
  input  logic           cmd_abort,
  input  logic           cmd_ring,
  input  logic           cmd_reverse,
  capture_ram_if.slave   s,
  output logic           busy,
  output logic [MAW:0]   fill
);

  localparam int EW = MDW + MKW + 1;

  state_t         state, state_nxt;
  logic           ring_q, rev_q;
  logic [MAW-1:0] wr_ptr, wr_ptr_inc, rd_ptr, rd_start;
  logic [MAW:0]   fill_inc, rd_cnt;
  logic           start_ok, wr_xfer, wr_en, full_hit, wr_done;
  logic           issue, issue_ok, rd_vld_q, rd_last_q, pop;
  logic [1:0]     skid_cnt, occ;
  logic [EW-1:0]  e0, e1, new_e;
  logic [MDW-1:0] ram_data;
  logic [MKW-1:0] ram_keep;

  assign start_ok   = (state == ST_IDLE) && cmd_start && !cmd_abort;
  assign wr_xfer    = (state == ST_WRITE) && s.mwr_tvalid;
  assign wr_en      = wr_xfer && !cmd_abort;
  assign full_hit   = !ring_q && (fill == (MAW+1)'(MSZ - 1));
  assign wr_done    = wr_xfer && (s.mwr_tlast || full_hit);
  assign wr_ptr_inc = MAW'(mod_inc(32'(wr_ptr), MSZ));
  assign fill_inc   = (fill == (MAW+1)'(MSZ)) ? fill : fill + 1'b1;
  assign rd_start   = rev_q ? MAW'(mod_dec(32'(wr_ptr_inc), MSZ))
                            : MAW'(mod_sub(32'(wr_ptr_inc), 32'(fill_inc), MSZ));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_start) state_nxt = ST_WRITE;
      ST_WRITE: if (wr_done) state_nxt = ST_READ;
      ST_READ:  if (pop && e0[EW-1]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (cmd_abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    s.mwr_tready = (state == ST_WRITE);
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
      ring_q <= 1'b0;
      rev_q  <= 1'b0;
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else begin
      if (start_ok) begin
        wr_ptr <= '0;
        fill   <= '0;
        ring_q <= cmd_ring;
        rev_q  <= cmd_reverse;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
        fill   <= fill_inc;
        if (wr_done) begin
          rd_ptr <= rd_start;
          rd_cnt <= '0;
        end
      end
      if (issue) begin
        rd_ptr <= rev_q ? MAW'(mod_dec(32'(rd_ptr), MSZ)) : MAW'(mod_inc(32'(rd_ptr), MSZ));
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Issue only while the skid plus the word in the RAM pipe leaves room after this cycle's pop
  assign pop      = (skid_cnt != 2'd0) && s.mrd_tready;
  assign occ      = skid_cnt + {1'b0, rd_vld_q};
  assign issue_ok = (occ - {1'b0, pop}) < 2'd2;
  assign issue    = (state == ST_READ) && (rd_cnt != fill) && issue_ok && !cmd_abort;

  always_ff @(posedge clk) begin
    if (rst || cmd_abort) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= (rd_cnt == fill - 1'b1);
    end
  end

  for (genvar i = 0; i < MKW; i++) begin : g_lane
    capture_ram_lane #(.MSZ(MSZ), .MAW(MAW)) u_lane (
      .clk   (clk),
      .we    (wr_en),
      .wkeep (s.mwr_tkeep[i]),
      .waddr (wr_ptr),
      .wdata (s.mwr_tdata[i*8 +: 8]),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (ram_data[i*8 +: 8]),
      .rkeep (ram_keep[i])
    );
  end

  assign new_e = {rd_last_q, ram_keep, ram_data};

  // Two-entry skid: e0 is the presented word, e1 catches the in-flight read during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      e0       <= '0;
      e1       <= '0;
    end else if (cmd_abort) begin
      skid_cnt <= 2'd0;
    end else begin
      case ({rd_vld_q, pop})
        2'b01: begin
          e0       <= e1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b10: begin
          if (skid_cnt == 2'd0) e0 <= new_e;
          else                  e1 <= new_e;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            e0 <= new_e;
          end else begin
            e0 <= e1;
            e1 <= new_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign s.mrd_tvalid = (skid_cnt != 2'd0);
  assign s.mrd_tdata  = e0[MDW-1:0];
  assign s.mrd_tkeep  = e0[MDW +: MKW];
  assign s.mrd_tlast  = e0[EW-1];

endmodule
